// File: rtl/uart_cmd_mcu.sv
// Byte-stream command sequencer: pops opcode/argument bytes from the UART RX FIFO and
// launches BRAM writes, BRAM-to-UART reads or one perceptron unit, then waits for its completion.
module uart_cmd_mcu #(
   parameter int unsigned ADDR_W     = 9,
   parameter int unsigned ADDR_BYTES = 2,
   parameter int unsigned N_UNITS    = 4,
   parameter int unsigned TIMEOUT    = 1000000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                uart_data_present,
   input  logic [7:0]          uart_data_in,
   output logic                uart_data_read,
   input  logic                bram_write_complete,
   output logic                write_to_bram,
   output logic [3:0]          bytes_to_write,
   output logic [ADDR_W-1:0]   bram_write_addr,
   input  logic                uart_send_complete,
   output logic                send_over_uart,
   output logic [3:0]          bytes_to_read,
   output logic [ADDR_W-1:0]   bram_read_addr,
   input  logic [N_UNITS-1:0]  perceptron_fire,
   output logic [N_UNITS-1:0]  perceptron_enable,
   output logic                busy,
   output logic                cmd_done,
   output logic                cmd_error,
   output logic [1:0]          error_code,
   output logic [2:0]          state
);

   localparam int unsigned HOLD_W = 8 * ADDR_BYTES;
   localparam int unsigned WD_W   = $clog2(TIMEOUT);
   localparam int unsigned ARGC_W = $clog2(ADDR_BYTES + 2);

   localparam logic [7:0] OP_WRITE = 8'h77;
   localparam logic [7:0] OP_READ  = 8'h72;
   localparam logic [7:0] OP_PERC  = 8'h70;

   localparam logic [1:0] ERR_OPCODE  = 2'd1;
   localparam logic [1:0] ERR_ARG     = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_OP_ACK    = 3'd1,
      S_DECODE    = 3'd2,
      S_ARG_WAIT  = 3'd3,
      S_ARG_ACK   = 3'd4,
      S_ISSUE     = 3'd5,
      S_WAIT_DONE = 3'd6,
      S_ERROR     = 3'd7
   } state_e;

   typedef enum logic [1:0] {
      CMD_W = 2'd0,
      CMD_R = 2'd1,
      CMD_P = 2'd2
   } cmd_e;

   state_e               state_q;
   cmd_e                 cmd_q;
   logic [7:0]           byte_q;
   logic [HOLD_W-1:0]    addr_hold_q;
   logic [ARGC_W-1:0]    argc_q;
   logic [WD_W-1:0]      wd_q;
   logic [N_UNITS-1:0]   sel_q;

   logic                 match;
   logic                 arg_ok;
   logic                 wd_expired;
   logic                 last_arg;

   assign busy  = (state_q != S_IDLE);
   assign state = state_q;

   // Only the completion belonging to the command in flight counts.
   always_comb begin
      match = 1'b0;
      case (cmd_q)
         CMD_W:   match = bram_write_complete;
         CMD_R:   match = uart_send_complete;
         default: match = |(perceptron_fire & sel_q);
      endcase
   end

   // The last latched argument is the length byte (w/r) or the unit index (p).
   always_comb begin
      arg_ok = 1'b0;
      if (cmd_q == CMD_P) arg_ok = (32'(byte_q) < N_UNITS);
      else                arg_ok = (byte_q[3:0] != 4'd0);
   end

   assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));
   assign last_arg   = (argc_q == ARGC_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q           <= S_IDLE;
         cmd_q             <= CMD_W;
         byte_q            <= '0;
         addr_hold_q       <= '0;
         argc_q            <= '0;
         wd_q              <= '0;
         sel_q             <= '0;
         uart_data_read    <= 1'b0;
         write_to_bram     <= 1'b0;
         bytes_to_write    <= '0;
         bram_write_addr   <= '0;
         send_over_uart    <= 1'b0;
         bytes_to_read     <= '0;
         bram_read_addr    <= '0;
         perceptron_enable <= '0;
         cmd_done          <= 1'b0;
         cmd_error         <= 1'b0;
         error_code        <= '0;
      end else begin
         uart_data_read    <= 1'b0;
         write_to_bram     <= 1'b0;
         send_over_uart    <= 1'b0;
         perceptron_enable <= '0;
         cmd_done          <= 1'b0;
         cmd_error         <= 1'b0;

         case (state_q)
            S_IDLE: begin
               if (uart_data_present) begin
                  byte_q         <= uart_data_in;
                  uart_data_read <= 1'b1;
                  state_q        <= S_OP_ACK;
               end
            end

            S_OP_ACK: state_q <= S_DECODE;

            S_DECODE: begin
               wd_q <= '0;
               case (byte_q)
                  OP_WRITE: begin
                     cmd_q      <= CMD_W;
                     argc_q     <= ARGC_W'(ADDR_BYTES + 1);
                     error_code <= '0;
                     state_q    <= S_ARG_WAIT;
                  end
                  OP_READ: begin
                     cmd_q      <= CMD_R;
                     argc_q     <= ARGC_W'(ADDR_BYTES + 1);
                     error_code <= '0;
                     state_q    <= S_ARG_WAIT;
                  end
                  OP_PERC: begin
                     cmd_q      <= CMD_P;
                     argc_q     <= ARGC_W'(1);
                     error_code <= '0;
                     state_q    <= S_ARG_WAIT;
                  end
                  default: begin
                     error_code <= ERR_OPCODE;
                     cmd_error  <= 1'b1;
                     state_q    <= S_ERROR;
                  end
               endcase
            end

            // Address bytes arrive MSB first; anything above HOLD_W falls off the top.
            S_ARG_WAIT: begin
               if (uart_data_present) begin
                  byte_q         <= uart_data_in;
                  uart_data_read <= 1'b1;
                  if (cmd_q != CMD_P && !last_arg)
                     addr_hold_q <= HOLD_W'({addr_hold_q, uart_data_in});
                  state_q        <= S_ARG_ACK;
               end else if (wd_expired) begin
                  error_code <= ERR_TIMEOUT;
                  cmd_error  <= 1'b1;
                  state_q    <= S_ERROR;
               end else begin
                  wd_q <= wd_q + WD_W'(1);
               end
            end

            S_ARG_ACK: begin
               if (!last_arg) begin
                  argc_q  <= argc_q - ARGC_W'(1);
                  wd_q    <= '0;
                  state_q <= S_ARG_WAIT;
               end else if (!arg_ok) begin
                  error_code <= ERR_ARG;
                  cmd_error  <= 1'b1;
                  state_q    <= S_ERROR;
               end else begin
                  case (cmd_q)
                     CMD_W: begin
                        bram_write_addr <= ADDR_W'(addr_hold_q);
                        bytes_to_write  <= byte_q[3:0];
                        write_to_bram   <= 1'b1;
                     end
                     CMD_R: begin
                        bram_read_addr <= ADDR_W'(addr_hold_q);
                        bytes_to_read  <= byte_q[3:0];
                        send_over_uart <= 1'b1;
                     end
                     default: begin
                        sel_q             <= N_UNITS'(1) << byte_q;
                        perceptron_enable <= N_UNITS'(1) << byte_q;
                     end
                  endcase
                  state_q <= S_ISSUE;
               end
            end

            // A completion that races the start pulse is still honoured here.
            S_ISSUE: begin
               if (match) begin
                  cmd_done <= 1'b1;
                  state_q  <= S_IDLE;
               end else begin
                  wd_q    <= '0;
                  state_q <= S_WAIT_DONE;
               end
            end

            S_WAIT_DONE: begin
               if (match) begin
                  cmd_done <= 1'b1;
                  state_q  <= S_IDLE;
               end else if (wd_expired) begin
                  error_code <= ERR_TIMEOUT;
                  cmd_error  <= 1'b1;
                  state_q    <= S_ERROR;
               end else begin
                  wd_q <= wd_q + WD_W'(1);
               end
            end

            S_ERROR: state_q <= S_IDLE;

            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cmd_mcu.sv
// Self-checking bench for uart_cmd_mcu: FIFO/completion responders driven per cycle,
// directed vector table, hand-written timing sequences and randomized commands vs. a command-level model.
module tb_uart_cmd_mcu;

   localparam int unsigned ADDR_W     = 9;
   localparam int unsigned ADDR_BYTES = 2;
   localparam int unsigned N_UNITS    = 4;
   localparam int unsigned TO         = 16;

   logic                clk = 1'b0;
   logic                rst;
   logic                present;
   logic [7:0]          din;
   logic                rd;
   logic                wcomp;
   logic                wr_start;
   logic [3:0]          wlen;
   logic [ADDR_W-1:0]   waddr;
   logic                scomp;
   logic                rd_start;
   logic [3:0]          rlen;
   logic [ADDR_W-1:0]   raddr;
   logic [N_UNITS-1:0]  fire;
   logic [N_UNITS-1:0]  en;
   logic                busy;
   logic                cmd_done;
   logic                cmd_error;
   logic [1:0]          error_code;
   logic [2:0]          state;

   always #5 clk = ~clk;

   uart_cmd_mcu #(
      .ADDR_W(ADDR_W), .ADDR_BYTES(ADDR_BYTES), .N_UNITS(N_UNITS), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .uart_data_present(present), .uart_data_in(din), .uart_data_read(rd),
      .bram_write_complete(wcomp), .write_to_bram(wr_start),
      .bytes_to_write(wlen), .bram_write_addr(waddr),
      .uart_send_complete(scomp), .send_over_uart(rd_start),
      .bytes_to_read(rlen), .bram_read_addr(raddr),
      .perceptron_fire(fire), .perceptron_enable(en),
      .busy(busy), .cmd_done(cmd_done), .cmd_error(cmd_error),
      .error_code(error_code), .state(state)
   );

   typedef struct {
      logic [7:0] op, a0, a1, a2;
      int         dly;       // cycles from start pulse to completion (large = never)
      bit         stray;     // drive non-matching completions while waiting
      bit         exp_done;
      logic [1:0] exp_code;
      int         exp_kind;  // 0 no start, 1 write, 2 read, 3 perceptron
      logic [8:0] exp_addr;
      logic [3:0] exp_len;
      logic [3:0] exp_en;
   } vec_t;

   int n_chk = 0, n_fail = 0, cyc = 0;
   logic [7:0] fifo[$];
   int hold = 0, max_gap = 0;
   int n_wr, n_rd, n_en, n_pop, done_seen, err_seen;
   int start_cyc, last_rd_cyc, done_cyc, err_cyc, comp_cyc;
   logic [8:0] cap_addr;
   logic [3:0] cap_len, cap_en;
   bit busy_at_done, underflow;
   bit armed = 0, stray_en = 0;
   int resp_cnt, resp_kind, cur_dly = 0;
   logic [3:0] resp_sel;
   logic [8:0] m_waddr = '0, m_raddr = '0;
   logic [3:0] m_wlen = '0, m_rlen = '0;
   vec_t vecs[12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int nargs_of(input logic [7:0] op);
      if (op == 8'h77 || op == 8'h72) return ADDR_BYTES + 1;
      if (op == 8'h70) return 1;
      return 0;
   endfunction

   function automatic vec_t mk(input logic [7:0] op, a0, a1, a2, input int dly, input bit stray,
                               input bit done, input logic [1:0] code, input int kind,
                               input logic [8:0] addr, input logic [3:0] len, input logic [3:0] e);
      vec_t v;
      v.op = op; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.dly = dly; v.stray = stray;
      v.exp_done = done; v.exp_code = code; v.exp_kind = kind;
      v.exp_addr = addr; v.exp_len = len; v.exp_en = e;
      return v;
   endfunction

   // Command-level reference: what a command should do, from its bytes and response delay.
   function automatic vec_t model(input vec_t v);
      vec_t r;
      int unsigned a, l, idx;
      r = v;
      r.exp_kind = 0; r.exp_addr = '0; r.exp_len = '0; r.exp_en = '0; r.exp_done = 0; r.exp_code = 2'd0;
      if (v.op == 8'h77 || v.op == 8'h72) begin
         a = (int'(v.a0) * 256 + int'(v.a1)) % (1 << ADDR_W);
         l = int'(v.a2) % 16;
         if (l == 0) r.exp_code = 2'd2;
         else begin
            r.exp_kind = (v.op == 8'h77) ? 1 : 2;
            r.exp_addr = 9'(a);
            r.exp_len  = 4'(l);
            r.exp_done = (v.dly <= int'(TO));
            r.exp_code = r.exp_done ? 2'd0 : 2'd3;
         end
      end else if (v.op == 8'h70) begin
         idx = int'(v.a0);
         if (idx >= N_UNITS) r.exp_code = 2'd2;
         else begin
            r.exp_kind = 3;
            r.exp_en   = 4'(1 << idx);
            r.exp_done = (v.dly <= int'(TO));
            r.exp_code = r.exp_done ? 2'd0 : 2'd3;
         end
      end else begin
         r.exp_code = 2'd1;
      end
      return r;
   endfunction

   task automatic clr();
      n_wr = 0; n_rd = 0; n_en = 0; n_pop = 0; done_seen = 0; err_seen = 0;
      start_cyc = -1; last_rd_cyc = -1; done_cyc = -1; err_cyc = -1; comp_cyc = -1;
      cap_addr = '0; cap_len = '0; cap_en = '0; busy_at_done = 1; underflow = 0; armed = 0;
   endtask

   task automatic arm(input int kind, input logic [3:0] sel);
      armed = 1; resp_kind = kind; resp_sel = sel; resp_cnt = cur_dly; start_cyc = cyc;
   endtask

   // One clock: sample outputs just after the edge, then update FIFO and responders.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (rd) begin
         n_pop++;
         last_rd_cyc = cyc;
         if (fifo.size() == 0) underflow = 1;
         else void'(fifo.pop_front());
         hold = $urandom_range(0, max_gap);
      end else if (hold > 0) begin
         hold--;
      end
      present = (fifo.size() > 0) && (hold == 0);
      din     = (fifo.size() > 0) ? fifo[0] : 8'h00;

      wcomp = 1'b0; scomp = 1'b0; fire = '0;
      if (wr_start) begin n_wr++; cap_addr = waddr; cap_len = wlen; arm(1, 4'h0); end
      if (rd_start) begin n_rd++; cap_addr = raddr; cap_len = rlen; arm(2, 4'h0); end
      if (en != '0) begin n_en++; cap_en = en; arm(3, en); end
      if (armed) begin
         if (stray_en) begin
            case (resp_kind)
               1: begin scomp = 1'b1; fire = 4'hF; end
               2: begin wcomp = 1'b1; fire = 4'hF; end
               default: begin wcomp = 1'b1; scomp = 1'b1; fire = ~resp_sel; end
            endcase
         end
         if (resp_cnt == 0) begin
            case (resp_kind)
               1: wcomp = 1'b1;
               2: scomp = 1'b1;
               default: fire = fire | resp_sel;
            endcase
            armed = 0;
            comp_cyc = cyc;
         end else begin
            resp_cnt--;
         end
      end
      if (cmd_done) begin done_seen++; done_cyc = cyc; busy_at_done = busy; end
      if (cmd_error) begin err_seen++; err_cyc = cyc; end
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int na;
      clr();
      cur_dly = v.dly; stray_en = v.stray;
      na = nargs_of(v.op);
      fifo.push_back(v.op);
      if (na >= 1) fifo.push_back(v.a0);
      if (na >= 3) begin fifo.push_back(v.a1); fifo.push_back(v.a2); end
      hold = $urandom_range(0, max_gap);
      for (int i = 0; i < 200 && done_seen == 0 && err_seen == 0; i++) tick();
      tick();
      tick();
      armed = 0; wcomp = 1'b0; scomp = 1'b0; fire = '0;

      check({tag, " finished"},   32'(done_seen + err_seen), 32'd1);
      check({tag, " done"},       32'(done_seen), 32'(v.exp_done));
      check({tag, " error_code"}, 32'(error_code), 32'(v.exp_code));
      check({tag, " wr_pulses"},  32'(n_wr), 32'(v.exp_kind == 1));
      check({tag, " rd_pulses"},  32'(n_rd), 32'(v.exp_kind == 2));
      check({tag, " en_pulses"},  32'(n_en), 32'(v.exp_kind == 3));
      check({tag, " fifo_pops"},  32'(n_pop), 32'(1 + na));
      check({tag, " underflow"},  32'(underflow), 32'd0);
      check({tag, " fifo_left"},  32'(fifo.size()), 32'd0);
      check({tag, " idle_state"}, 32'(state), 32'd0);
      check({tag, " idle_busy"},  32'(busy), 32'd0);
      if (v.exp_kind == 1 || v.exp_kind == 2) begin
         check({tag, " addr"}, 32'(cap_addr), 32'(v.exp_addr));
         check({tag, " len"},  32'(cap_len), 32'(v.exp_len));
      end
      if (v.exp_kind == 3) check({tag, " enable"}, 32'(cap_en), 32'(v.exp_en));
      if (v.exp_kind != 0) check({tag, " start_lat"}, 32'(start_cyc - last_rd_cyc), 32'd1);
      if (v.exp_done) begin
         check({tag, " done_lat"},  32'(done_cyc - comp_cyc), 32'd1);
         check({tag, " done_busy"}, 32'(busy_at_done), 32'd0);
      end
      if (v.exp_kind != 0 && v.exp_code == 2'd3)
         check({tag, " wd_lat"}, 32'(err_cyc - start_cyc), 32'(TO + 1));

      if (v.exp_kind == 1) begin m_waddr = v.exp_addr; m_wlen = v.exp_len; end
      if (v.exp_kind == 2) begin m_raddr = v.exp_addr; m_rlen = v.exp_len; end
      check({tag, " hold_waddr"}, 32'(waddr), 32'(m_waddr));
      check({tag, " hold_wlen"},  32'(wlen),  32'(m_wlen));
      check({tag, " hold_raddr"}, 32'(raddr), 32'(m_raddr));
      check({tag, " hold_rlen"},  32'(rlen),  32'(m_rlen));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "global timeout");
   end

   initial begin
      vec_t v;
      int e;
      rst = 1'b1; present = 1'b0; din = '0; wcomp = 1'b0; scomp = 1'b0; fire = '0;
      clr();
      repeat (3) @(posedge clk);
      #1;
      check("rst state",   32'(state), 32'd0);
      check("rst busy",    32'(busy), 32'd0);
      check("rst pulses",  32'({rd, wr_start, rd_start, en, cmd_done, cmd_error}), 32'd0);
      check("rst waddr",   32'(waddr), 32'd0);
      check("rst raddr",   32'(raddr), 32'd0);
      check("rst lens",    32'({wlen, rlen}), 32'd0);
      check("rst errcode", 32'(error_code), 32'd0);
      rst = 1'b0;

      vecs[0]  = mk(8'h77, 8'h01, 8'h2A, 8'h04,  3, 0, 1, 2'd0, 1, 9'h12A, 4'd4, 4'h0);
      vecs[1]  = mk(8'h72, 8'hFF, 8'h05, 8'h13,  4, 1, 1, 2'd0, 2, 9'h105, 4'd3, 4'h0);
      vecs[2]  = mk(8'h70, 8'h02, 8'h00, 8'h00,  2, 1, 1, 2'd0, 3, 9'h000, 4'd0, 4'b0100);
      vecs[3]  = mk(8'h78, 8'h00, 8'h00, 8'h00,  0, 0, 0, 2'd1, 0, 9'h000, 4'd0, 4'h0);
      vecs[4]  = mk(8'h70, 8'h04, 8'h00, 8'h00,  0, 0, 0, 2'd2, 0, 9'h000, 4'd0, 4'h0);
      vecs[5]  = mk(8'h77, 8'h00, 8'h00, 8'h00,  0, 0, 0, 2'd2, 0, 9'h000, 4'd0, 4'h0);
      vecs[6]  = mk(8'h70, 8'h00, 8'h00, 8'h00, 99, 0, 0, 2'd3, 3, 9'h000, 4'd0, 4'b0001);
      vecs[7]  = mk(8'h77, 8'h00, 8'h00, 8'hF0,  0, 0, 0, 2'd2, 0, 9'h000, 4'd0, 4'h0);
      vecs[8]  = mk(8'h72, 8'h12, 8'h34, 8'h1F,  0, 1, 1, 2'd0, 2, 9'h034, 4'hF, 4'h0);
      vecs[9]  = mk(8'h77, 8'h01, 8'hFF, 8'h21, 16, 0, 1, 2'd0, 1, 9'h1FF, 4'd1, 4'h0);
      vecs[10] = mk(8'h77, 8'h01, 8'h55, 8'h01, 17, 0, 0, 2'd3, 1, 9'h155, 4'd1, 4'h0);
      vecs[11] = mk(8'h70, 8'h03, 8'h00, 8'h00,  1, 1, 1, 2'd0, 3, 9'h000, 4'd0, 4'b1000);

      max_gap = 0;
      foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Opcode latency, then argument-wait timeout with no further bytes.
      clr(); cur_dly = 99; stray_en = 0; hold = 0;
      fifo.push_back(8'h72);
      tick();
      check("lat t state",  32'({present, state}), 32'({1'b1, 3'd0}));
      tick();
      check("lat t+1 read", 32'(rd), 32'd1);
      check("lat t+1 state", 32'(state), 32'd1);
      tick();
      check("lat t+2 state", 32'({rd, state}), 32'({1'b0, 3'd2}));
      tick();
      check("lat t+3 state", 32'(state), 32'd3);
      e = cyc;
      for (int k = 0; k < int'(TO) - 1; k++) tick();
      check("argwd pre state", 32'(state), 32'd3);
      check("argwd pre err",   32'(err_seen), 32'd0);
      tick();
      check("argwd err pulse", 32'({cmd_error, error_code, state}), 32'({1'b1, 2'd3, 3'd7}));
      check("argwd err cycle", 32'(err_cyc - e), 32'(TO));
      check("argwd no start",  32'(n_wr + n_rd + n_en), 32'd0);
      tick();
      check("argwd back idle", 32'({cmd_error, state}), 32'd0);

      // Asynchronous reset in the middle of an argument wait, off the clock edge.
      clr(); hold = 0;
      fifo.push_back(8'h77);
      fifo.push_back(8'h01);
      for (int k = 0; k < 20; k++) begin
         tick();
         if (n_pop == 2 && state == 3'd3) break;
      end
      check("rst mid argwait", 32'(state), 32'd3);
      #3 rst = 1'b1;
      #1;
      check("arst state",  32'({busy, state}), 32'd0);
      check("arst pulses", 32'({rd, wr_start, rd_start, en, cmd_done, cmd_error}), 32'd0);
      check("arst waddr",  32'(waddr), 32'd0);
      check("arst raddr",  32'(raddr), 32'd0);
      check("arst lens",   32'({wlen, rlen}), 32'd0);
      #3 rst = 1'b0;
      fifo.delete(); hold = 0;
      m_waddr = '0; m_raddr = '0; m_wlen = '0; m_rlen = '0;
      run_vec(mk(8'h70, 8'h00, 8'h00, 8'h00, 2, 0, 1, 2'd0, 3, 9'h000, 4'd0, 4'b0001), "post_rst");

      // Randomized commands against the command-level model.
      max_gap = 4;
      for (int n = 0; n < 40; n++) begin
         case ($urandom % 8)
            0, 1: v.op = 8'h77;
            2, 3: v.op = 8'h72;
            4, 5: v.op = 8'h70;
            default: v.op = 8'($urandom);
         endcase
         v.a0    = (v.op == 8'h70) ? 8'($urandom_range(0, 5)) : 8'($urandom);
         v.a1    = 8'($urandom);
         v.a2    = {4'($urandom), 4'($urandom_range(0, 15))};
         v.dly   = ($urandom % 4 == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 6));
         v.stray = 1'($urandom);
         v = model(v);
         run_vec(v, $sformatf("rnd%0d_op%02h", n, v.op));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_cmd_mcu.md
# uart_cmd_mcu

Parametrised UART command sequencer that decodes byte-stream commands from the UART RX FIFO and drives the BRAM write path, the BRAM-to-UART read path and an array of perceptron units. It sits between the UART RX FIFO and the BRAM/perceptron datapath. Compared with the previous single-address-byte controller, it adds:
- multi-byte addresses;
- a per-command length byte in place of switch-selected lengths;
- N selectable perceptron units;
- completion matching per command;
- argument validation and a watchdog timeout with error reporting.

## Interface
- ADDR_W, 9, BRAM address width (1..16)
- ADDR_BYTES, 2, address bytes per r/w command, MSB first; must satisfy 8*ADDR_BYTES >= ADDR_W
- N_UNITS, 4, perceptron unit count (1..255)
- TIMEOUT, 1000000, cycles allowed while waiting for an argument byte or a completion (>= 2)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- uart_data_present  in  1  RX FIFO non-empty
- uart_data_in  in  8  RX FIFO head byte
- uart_data_read  out  1  one-cycle FIFO pop
- bram_write_complete  in  1  write path done pulse
- write_to_bram  out  1  one-cycle write start
- bytes_to_write  out  4  write length
- bram_write_addr  out  ADDR_W  write address
- uart_send_complete  in  1  read path done pulse
- send_over_uart  out  1  one-cycle read start
- bytes_to_read  out  4  read length
- bram_read_addr  out  ADDR_W  read address
- perceptron_fire  in  N_UNITS  per-unit done pulse
- perceptron_enable  out  N_UNITS  one-hot, one-cycle start
- busy  out  1  high in every state except IDLE
- cmd_done  out  1  one-cycle pulse on successful completion
- cmd_error  out  1  one-cycle pulse on abort
- error_code  out  2  0 none, 1 bad opcode, 2 bad argument, 3 timeout
- state  out  3  current state encoding, for debug LEDs

## Operation
States and encodings: IDLE=0, OP_ACK=1, DECODE=2, ARG_WAIT=3, ARG_ACK=4, ISSUE=5, WAIT_DONE=6, ERROR=7.

Byte consume rule:
- A byte is taken only in IDLE or ARG_WAIT, and only when uart_data_present=1.
- The byte is latched at that clock edge.
- The next state (OP_ACK/ARG_ACK) asserts uart_data_read for exactly one cycle.
- uart_data_present is ignored in the ACK states, which gives the FIFO one cycle to update.

Opcodes:
- 'w' (0x77): ADDR_BYTES+1 argument bytes.
- 'r' (0x72): ADDR_BYTES+1 argument bytes.
- 'p' (0x70): 1 argument byte.
- Any other opcode: DECODE -> ERROR with code 1.
- An accepted opcode clears error_code to 0.

Argument handling:
- Address bytes shift into a holding register MSB first; the low ADDR_W bits are used and upper bits are discarded.
- Length byte: bits[3:0] give the length; bits[7:4] are ignored; a length of 0 is an error (code 2).
- 'p' argument: unit index; an index >= N_UNITS is an error (code 2).

Transitions:
- IDLE -> OP_ACK -> DECODE -> ARG_WAIT.
- ARG_WAIT -> ARG_ACK when present; ARG_WAIT -> ERROR with code 3 on timeout.
- ARG_ACK -> ARG_WAIT if more arguments remain; otherwise -> ISSUE if the arguments are valid, else -> ERROR.
- ISSUE -> WAIT_DONE.
- WAIT_DONE -> IDLE with cmd_done on a matching completion; WAIT_DONE -> ERROR with code 3 on timeout.
- ERROR -> IDLE. cmd_error pulses in the ERROR cycle.

ISSUE actions:
- 'w': load bram_write_addr and bytes_to_write; pulse write_to_bram.
- 'r': load bram_read_addr and bytes_to_read; pulse send_over_uart.
- 'p': pulse perceptron_enable[idx].
- Address and length registers hold their values until the next ISSUE of the same type.

Completion matching:
- 'w' waits only on bram_write_complete.
- 'r' waits only on uart_send_complete.
- 'p' waits only on perceptron_fire[idx].
- Non-matching completions are ignored.
- A matching completion arriving in the ISSUE cycle is accepted: ISSUE -> IDLE with cmd_done.

Watchdog:
- The counter clears on entry to ARG_WAIT or WAIT_DONE.
- It increments every cycle spent in those states.
- It fires when the count reaches TIMEOUT-1 with no event.

Reset: asserting rst mid-command aborts immediately with no pulses and no pending completion retained.

## Timing
- Reset values: state=IDLE, all pulses 0, addresses 0, lengths 0, error_code 0, busy 0.
- All outputs are registered or decoded from state only; there is no input-to-output combinational path.
- Opcode byte present at cycle t in IDLE: uart_data_read=1 at t+1, DECODE at t+2, ARG_WAIT at t+3.
- Each argument byte costs 2 cycles minimum (wait/latch + ack).
- Last argument acked at cycle a: the start pulse is asserted at a+1.
- Completion at cycle c (c > ISSUE cycle): cmd_done at c+1, IDLE at c+1, busy=0 from c+1.
- A new opcode can be latched in the first IDLE cycle.

## Test plan
- Write, ADDR_W=9: 'w',0x01,0x2A,0x04 -> write_to_bram pulses once with bram_write_addr=0x12A and bytes_to_write=4; bram_write_complete 3 cycles later -> cmd_done, busy falls.
- Read with address truncation: 'r',0xFF,0x05,0x13 -> bram_read_addr=0x105, bytes_to_read=3. A uart_send_complete is required for cmd_done, and a stray bram_write_complete is ignored.
- Perceptron, N_UNITS=4: 'p',0x02 -> perceptron_enable=4'b0100 for one cycle; perceptron_fire=4'b0001 is ignored; 4'b0100 -> cmd_done.
- Errors: 'x' -> cmd_error with error_code=1 and no start pulses. 'p',0x04 -> error_code=2. 'w',0,0,0x00 -> error_code=2.
- Timeout with TIMEOUT=16: 'r' then silence -> cmd_error with error_code=3 exactly 16 cycles after ARG_WAIT entry. Also issue 'p',0 with no fire -> timeout in WAIT_DONE.
- Async rst asserted mid-ARG_WAIT, off a clock edge -> outputs reach their reset values immediately; the next 'p',0 executes normally.
